// File: rtl/phase_decimator.sv
// rtl/phase_decimator.sv - phase-aligned windowed averager with a 2-entry output buffer
module phase_decimator #(
   parameter int DATA_W     = 8,
   parameter int DECIM_LOG2 = 2,
   parameter int PHASE_W    = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [PHASE_W-1:0]            subsample_phase,
   input  logic [DATA_W-1:0]             sample_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_data,
   output logic [PHASE_W-DECIM_LOG2-1:0] out_tag,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int ACC_W = DATA_W + DECIM_LOG2;
   localparam int TAG_W = PHASE_W - DECIM_LOG2;

   typedef enum logic [1:0] {IDLE, SYNC, ACCUM} state_t;

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  sum;
   logic [ACC_W-1:0]  sample_ext;
   logic [DECIM_LOG2-1:0] lo;
   logic              start_c, end_c, push;
   logic [DATA_W-1:0] result;
   logic [TAG_W-1:0]  tag;

   assign lo         = subsample_phase[DECIM_LOG2-1:0];
   assign start_c    = (lo == '0);
   assign end_c      = (lo == '1);
   assign sample_ext = {{DECIM_LOG2{1'b0}}, sample_in};
   assign sum        = acc_q + sample_ext;
   // Dropping the low DECIM_LOG2 bits is the truncating divide by the window length.
   assign result     = sum[ACC_W-1:DECIM_LOG2];
   assign tag        = subsample_phase[PHASE_W-1:DECIM_LOG2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               if (start_c) begin
                  acc_d   = sample_ext;
                  state_d = ACCUM;
               end else begin
                  state_d = SYNC;
               end
            end
         end
         SYNC: begin
            if (!en) begin
               state_d = IDLE;
            end else if (start_c) begin
               acc_d   = sample_ext;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (!en) begin
               state_d = IDLE;
               acc_d   = '0;
            end else if (start_c) begin
               acc_d = sample_ext;
            end else if (end_c) begin
               push = 1'b1;
            end else begin
               acc_d = sum;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   logic              head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
   logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [TAG_W-1:0]  head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
   logic              ovf_q, ovf_d, pop, drop;

   assign pop = head_vld_q && out_ready;

   // The pop is applied first so a push in the same cycle sees the freed slot.
   always_comb begin
      head_vld_d  = head_vld_q;
      tail_vld_d  = tail_vld_q;
      head_data_d = head_data_q;
      head_tag_d  = head_tag_q;
      tail_data_d = tail_data_q;
      tail_tag_d  = tail_tag_q;
      drop        = 1'b0;
      if (pop) begin
         if (tail_vld_q) begin
            head_data_d = tail_data_q;
            head_tag_d  = tail_tag_q;
            tail_vld_d  = 1'b0;
         end else begin
            head_vld_d = 1'b0;
         end
      end
      if (push) begin
         if (!head_vld_d) begin
            head_data_d = result;
            head_tag_d  = tag;
            head_vld_d  = 1'b1;
         end else if (!tail_vld_d) begin
            tail_data_d = result;
            tail_tag_d  = tag;
            tail_vld_d  = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
      ovf_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_vld_q  <= 1'b0;
         tail_vld_q  <= 1'b0;
         head_data_q <= '0;
         head_tag_q  <= '0;
         tail_data_q <= '0;
         tail_tag_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         head_vld_q  <= head_vld_d;
         tail_vld_q  <= tail_vld_d;
         head_data_q <= head_data_d;
         head_tag_q  <= head_tag_d;
         tail_data_q <= tail_data_d;
         tail_tag_q  <= tail_tag_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = head_vld_q;
   assign out_data  = head_data_q;
   assign out_tag   = head_tag_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_phase_decimator.sv
// tb/tb_phase_decimator.sv - randomized and directed bench for phase_decimator
module tb_phase_decimator;

   logic       clk = 1'b0;
   logic       rst_n, en, rdy, clr;
   logic [9:0] ph;
   logic [7:0] smp;
   logic       ov, of;
   logic [7:0] od, ot;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq_d[$];
   logic [7:0] mq_t[$];
   bit         m_ovf;
   bit         m_inwin;
   int         m_sum;

   always #5 clk = ~clk;

   phase_decimator #(.DATA_W(8), .DECIM_LOG2(2), .PHASE_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .subsample_phase(ph), .sample_in(smp),
      .out_valid(ov), .out_ready(rdy), .out_data(od), .out_tag(ot),
      .overflow(of), .clr_overflow(clr)
   );

   task automatic model_clear();
      mq_d.delete();
      mq_t.delete();
      m_ovf   = 0;
      m_inwin = 0;
      m_sum   = 0;
   endtask

   // Window of 4 phases: averaged only if en held from its start phase to its end phase.
   task automatic cycle(input bit e, input int p, input int s, input bit r, input bit c);
      bit pop, emit, drop;
      int pw;
      pw  = p % 1024;
      en  = e;
      ph  = pw[9:0];
      smp = s[7:0];
      rdy = r;
      clr = c;
      emit = 0;
      drop = 0;
      pop  = (mq_d.size() > 0) && r;
      if (!e) begin
         m_inwin = 0;
      end else if (pw % 4 == 0) begin
         m_inwin = 1;
         m_sum   = s;
      end else if (m_inwin) begin
         m_sum = m_sum + s;
         if (pw % 4 == 3) begin
            emit    = 1;
            m_inwin = 0;
         end
      end
      if (pop) begin
         void'(mq_d.pop_front());
         void'(mq_t.pop_front());
      end
      if (emit) begin
         if (mq_d.size() < 2) begin
            mq_d.push_back(8'(m_sum / 4));
            mq_t.push_back(8'(pw / 4));
         end else begin
            drop = 1;
         end
      end
      m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 0; rdy = 0; clr = 0; ph = '0; smp = '0;
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 0; rdy = 0; clr = 0; ph = '0; smp = '0;
      model_clear();
      #3;
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", ov); end
      total++; if (od !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", od); end
      total++; if (ot !== 8'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", ot); end
      total++; if (of !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", of); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      cycle(1, 0, 10, 0, 0);
      cycle(1, 1, 20, 0, 0);
      cycle(1, 2, 30, 0, 0);
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL basic_early got=%0d exp=0", ov); end
      cycle(1, 3, 40, 0, 0);
      total++; if (ov !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d exp=1", ov); end
      total++; if (od !== 8'd25) begin bad++; $display("FAIL basic_data got=%0d exp=25", od); end
      total++; if (ot !== 8'd0) begin bad++; $display("FAIL basic_tag got=%0d exp=0", ot); end
      cycle(1, 4, 0, 0, 0);
      cycle(1, 5, 0, 0, 0);
      total++; if (ov !== 1'b1 || od !== 8'd25 || ot !== 8'd0) begin
         bad++; $display("FAIL basic_stable got=%0d/%0d/%0d exp=1/25/0", ov, od, ot);
      end
      cycle(1, 6, 0, 1, 0);
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL basic_pop got=%0d exp=0", ov); end
   endtask

   task automatic test_truncate();
      do_reset();
      for (int p = 0; p < 4; p++) cycle(1, p, 255, 1, 0);
      total++; if (od !== 8'd255 || ov !== 1'b1) begin
         bad++; $display("FAIL trunc_max got=%0d/%0d exp=255/1", od, ov);
      end
      cycle(1, 4, 1, 1, 0);
      cycle(1, 5, 1, 1, 0);
      cycle(1, 6, 1, 1, 0);
      cycle(1, 7, 2, 1, 0);
      total++; if (od !== 8'd1 || ot !== 8'd1 || ov !== 1'b1) begin
         bad++; $display("FAIL trunc_small got=%0d/%0d/%0d exp=1/1/1", od, ot, ov);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int p = 0; p < 12; p++) cycle(1, p, int'($urandom_range(0, 255)), 0, 0);
      total++; if (of !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0d exp=1", of); end
      total++; if (ot !== 8'd0 || od !== mq_d[0]) begin
         bad++; $display("FAIL ovf_head0 got=%0d/%0d exp=0/%0d", ot, od, mq_d[0]);
      end
      cycle(0, 12, 0, 1, 0);
      total++; if (ot !== 8'd1 || od !== mq_d[0]) begin
         bad++; $display("FAIL ovf_head1 got=%0d/%0d exp=1/%0d", ot, od, mq_d[0]);
      end
      cycle(0, 13, 0, 1, 0);
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", ov); end
      total++; if (of !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d exp=1", of); end
      cycle(0, 14, 0, 0, 1);
      total++; if (of !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0d exp=0", of); end
      for (int p = 15; p < 27; p++) cycle(1, p, int'($urandom_range(0, 255)), 0, 0);
      total++; if (of !== 1'b0) begin bad++; $display("FAIL ovf_preclr got=%0d exp=0", of); end
      cycle(1, 27, 7, 0, 1);
      total++; if (of !== 1'b1) begin bad++; $display("FAIL ovf_setwins got=%0d exp=1", of); end
      total++; if (ot !== 8'd4) begin bad++; $display("FAIL ovf_tag4 got=%0d exp=4", ot); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int p = 0; p < 11; p++) cycle(1, p, int'($urandom_range(0, 255)), 0, 0);
      cycle(1, 11, int'($urandom_range(0, 255)), 1, 0);
      total++; if (ov !== 1'b1 || ot !== 8'd1 || od !== mq_d[0]) begin
         bad++; $display("FAIL full_head got=%0d/%0d/%0d exp=1/1/%0d", ov, ot, od, mq_d[0]);
      end
      total++; if (of !== 1'b0) begin bad++; $display("FAIL full_noovf got=%0d exp=0", of); end
      cycle(0, 12, 0, 1, 0);
      total++; if (ot !== 8'd2 || od !== mq_d[0]) begin
         bad++; $display("FAIL full_new got=%0d/%0d exp=2/%0d", ot, od, mq_d[0]);
      end
   endtask

   task automatic test_sync();
      do_reset();
      for (int p = 0; p < 16; p++) begin
         cycle((p >= 5 && p <= 12), p, int'($urandom_range(0, 255)), 1, 0);
         total++; if (ov !== (p == 11)) begin
            bad++; $display("FAIL sync_valid p=%0d got=%0d exp=%0d", p, ov, (p == 11));
         end
         if (p == 11) begin
            total++; if (ot !== 8'd2 || od !== mq_d[0]) begin
               bad++; $display("FAIL sync_first got=%0d/%0d exp=2/%0d", ot, od, mq_d[0]);
            end
         end
      end
      for (int p = 16; p < 23; p++) begin
         cycle(p != 16, p, int'($urandom_range(0, 255)), 0, 0);
         total++; if (ov !== 1'b0) begin bad++; $display("FAIL sync_idle p=%0d got=%0d exp=0", p, ov); end
      end
      cycle(1, 23, 9, 0, 0);
      total++; if (ov !== 1'b1 || ot !== 8'd5 || od !== mq_d[0]) begin
         bad++; $display("FAIL sync_resume got=%0d/%0d/%0d exp=1/5/%0d", ov, ot, od, mq_d[0]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int p = 1020; p < 1024; p++) cycle(1, p, int'($urandom_range(0, 255)), 0, 0);
      total++; if (ot !== 8'd255 || od !== mq_d[0]) begin
         bad++; $display("FAIL wrap_tag255 got=%0d/%0d exp=255/%0d", ot, od, mq_d[0]);
      end
      for (int p = 0; p < 4; p++) cycle(1, p, int'($urandom_range(0, 255)), 0, 0);
      cycle(1, 4, 3, 1, 0);
      total++; if (ot !== 8'd0 || od !== mq_d[0] || mq_d.size() != 1) begin
         bad++; $display("FAIL wrap_tag0 got=%0d/%0d exp=0/%0d", ot, od, mq_d[0]);
      end
      cycle(1, 5, 3, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (ov !== 1'b0 || od !== 8'd0 || ot !== 8'd0) begin
         bad++; $display("FAIL wrap_async got=%0d/%0d/%0d exp=0/0/0", ov, od, ot);
      end
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int p = 0; p < 4; p++) cycle(1, p, int'($urandom_range(0, 255)), 0, 0);
      total++; if (ov !== 1'b1 || ot !== 8'd0 || od !== mq_d[0]) begin
         bad++; $display("FAIL wrap_resume got=%0d/%0d/%0d exp=1/0/%0d", ov, ot, od, mq_d[0]);
      end
   endtask

   task automatic test_random();
      int p;
      do_reset();
      p = int'($urandom_range(0, 1023));
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 16) != 0, p, int'($urandom_range(0, 255)),
               ($urandom % 3) == 0, ($urandom % 8) == 0);
         p = (p + 1) % 1024;
         total++; if (ov !== (mq_d.size() > 0) || of !== m_ovf) begin
            bad++; $display("FAIL rand_flags i=%0d got=%0d/%0d exp=%0d/%0d", i, ov, of, (mq_d.size() > 0), m_ovf);
         end
         if (mq_d.size() > 0) begin
            total++; if (od !== mq_d[0] || ot !== mq_t[0]) begin
               bad++; $display("FAIL rand_head i=%0d got=%0d/%0d exp=%0d/%0d", i, od, ot, mq_d[0], mq_t[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_truncate();
      test_overflow();
      test_full_pop();
      test_sync();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
